// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg -- shared definitions for the 4-way round-robin arbiter.
//   NUM_REQ     : number of requesters
//   ID_W        : width of a requester index
//   arb_state_t : arbiter FSM state (IDLE, GRANT)
//   rr_pick     : circular priority scan starting at a pointer
package rr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Returns the first set request bit found scanning ptr, ptr+1, ... (mod NUM_REQ).
  // Result is meaningless when req is all-zero; callers qualify it with |req.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [ID_W-1:0]    ptr
  );
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] pick;
    logic            found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Index arithmetic wraps naturally in ID_W bits.
      idx = ptr + k[ID_W-1:0];
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_decoder.sv
// decoder_2X4 -- 2-bit binary index to 4-bit one-hot, with enable.
//   i_idx    : binary index (0..3)
//   i_en     : when low, output is forced all-zero
//   o_onehot : one-hot decode of i_idx, or zero when disabled
module decoder_2X4
  import rr_arb_pkg::*;
(
  input  logic [ID_W-1:0]    i_idx,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_onehot
);

  // Pure combinational decode.
  always_comb begin
    o_onehot = 4'b0000;
    if (i_en) begin
      case (i_idx)
        2'd0:    o_onehot = 4'b0001;
        2'd1:    o_onehot = 4'b0010;
        2'd2:    o_onehot = 4'b0100;
        2'd3:    o_onehot = 4'b1000;
        default: o_onehot = 4'b0000;
      endcase
    end else begin
      o_onehot = 4'b0000;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4 -- 4-requester round-robin arbiter with bounded hold time.
// A grant is issued from IDLE to the first requester at or after the
// round-robin pointer, held until done, request drop or MAX_HOLD cycles,
// and always followed by at least one IDLE cycle.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req[3:0]  : level-sensitive requests
//   done      : owner releases its grant (ignored in IDLE)
//   gnt[3:0]  : one-hot grant, zero when no owner
//   gnt_id    : binary owner index, zero when no owner
//   gnt_valid : high while a grant is held
//   timeout   : one-cycle pulse after a grant revoked purely by MAX_HOLD
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  arb_state_t          r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_gnt_id;
  logic                r_gnt_valid;
  logic [7:0]          r_hold_cnt;
  logic                r_timeout;

  logic [ID_W-1:0]     w_winner;
  logic                w_any_req;
  logic                w_owner_req;
  logic                w_at_limit;
  logic                w_release;
  logic                w_expire;
  logic [NUM_REQ-1:0]  w_gnt;

  // Arbitration and release conditions, all from inputs and current registers.
  always_comb begin
    w_winner    = rr_pick(req, r_ptr);
    w_any_req   = |req;
    w_owner_req = req[r_gnt_id];
    w_at_limit  = (r_hold_cnt == HOLD_LIMIT);
    w_release   = done | ~w_owner_req | w_at_limit;
    // Timeout only when expiry is the sole reason for the release.
    w_expire    = w_at_limit & ~done & w_owner_req;
  end

  // Arbiter FSM with registered owner, pointer, hold counter and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 2'd0;
      r_gnt_id    <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_hold_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (w_any_req) begin
            r_state     <= GRANT;
            r_gnt_id    <= w_winner;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= 8'd1;
          end else begin
            r_state     <= IDLE;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= 8'd0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state     <= IDLE;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= 8'd0;
            // Next search starts just past the releasing owner.
            r_ptr       <= r_gnt_id + 2'd1;
            r_timeout   <= w_expire;
          end else begin
            r_state     <= GRANT;
            r_hold_cnt  <= r_hold_cnt + 8'd1;
            r_timeout   <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_gnt_id    <= 2'd0;
          r_gnt_valid <= 1'b0;
          r_hold_cnt  <= 8'd0;
          r_timeout   <= 1'b0;
        end
      endcase
    end
  end

  // gnt is a decode of registers, so asynchronous reset clears it at once.
  decoder_2X4 u_gnt_dec (
    .i_idx    (r_gnt_id),
    .i_en     (r_gnt_valid),
    .o_onehot (w_gnt)
  );

  assign gnt       = w_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4 -- directed plus randomized self-checking bench for rr_arbiter_4.
// The reference model tracks the owner as an integer (-1 = none), a
// round-robin pointer and a hold count, applying the arbiter rules directly.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   m_owner;
  int   m_ptr;
  int   m_hold;
  logic m_timeout;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_hold    = 0;
    m_timeout = 1'b0;
  endtask

  // One clock edge of the reference rules, using the sampled inputs.
  task automatic model_edge(input logic [3:0] r, input logic d);
    bit rel;
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_hold  = 1;
        end
      end
    end else begin
      rel = d || !r[m_owner] || (m_hold == MAX_HOLD);
      if (rel) begin
        m_timeout = (m_hold == MAX_HOLD) && !d && r[m_owner];
        m_ptr     = (m_owner + 1) % 4;
        m_owner   = -1;
        m_hold    = 0;
      end else begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    logic [3:0] one;
    one = 4'b0001;
    if (m_owner < 0) return 4'b0000;
    return one << m_owner;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},       {4'b0000, gnt},       {4'b0000, exp_gnt()});
    chk({tag, ".gnt_id"},    {6'b000000, gnt_id},  (m_owner < 0) ? 8'd0 : 8'(m_owner));
    chk({tag, ".gnt_valid"}, {7'b0000000, gnt_valid}, {7'b0000000, (m_owner >= 0)});
    chk({tag, ".timeout"},   {7'b0000000, timeout},   {7'b0000000, m_timeout});
  endtask

  task automatic step(input logic [3:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] seq [9];
    logic [3:0] r;
    logic       d;
    seq[0] = 4'b0001; seq[1] = 4'b0000; seq[2] = 4'b0010; seq[3] = 4'b0000;
    seq[4] = 4'b0100; seq[5] = 4'b0000; seq[6] = 4'b1000; seq[7] = 4'b0000;
    seq[8] = 4'b0001;

    // Reset
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests, done in IDLE ignored
    step(4'b0000, 1'b0, "idle0");
    step(4'b0000, 1'b1, "idle_done");

    // Fairness with all requests and done pulsed one cycle after each grant
    for (int i = 0; i < 9; i++) begin
      step(4'b1111, (m_owner >= 0), "fair");
      chk("fair_seq", {4'b0000, gnt}, {4'b0000, seq[i]});
    end
    step(4'b0000, 1'b0, "fair_end");
    step(4'b0000, 1'b0, "fair_idle");

    // Hold expiry: single requester, never done
    step(4'b0100, 1'b0, "hold_grant");
    for (int i = 0; i < 15; i++) step(4'b0100, 1'b0, "hold");
    chk("hold_still", {4'b0000, gnt}, 8'h04);
    step(4'b0100, 1'b0, "expire");
    chk("expire_gnt", {4'b0000, gnt}, 8'h00);
    chk("expire_to", {7'b0000000, timeout}, 8'h01);
    step(4'b0100, 1'b0, "regrant");
    chk("regrant_gnt", {4'b0000, gnt}, 8'h04);
    chk("regrant_to", {7'b0000000, timeout}, 8'h00);

    // done coinciding with expiry: release without timeout
    for (int i = 0; i < 15; i++) step(4'b0100, 1'b0, "hold2");
    step(4'b0100, 1'b1, "expire_done");
    chk("expire_done_to", {7'b0000000, timeout}, 8'h00);
    chk("expire_done_gnt", {4'b0000, gnt}, 8'h00);

    // Pointer wrap 3 -> 0
    step(4'b1000, 1'b0, "own3");
    chk("own3_gnt", {4'b0000, gnt}, 8'h08);
    step(4'b1001, 1'b1, "own3_rel");
    step(4'b1001, 1'b0, "wrap");
    chk("wrap_gnt", {4'b0000, gnt}, 8'h01);
    step(4'b0000, 1'b0, "wrap_rel");

    // Request drop by owner 1 with requester 2 waiting
    step(4'b0010, 1'b0, "own1");
    chk("own1_gnt", {4'b0000, gnt}, 8'h02);
    step(4'b0100, 1'b0, "drop");
    chk("drop_gnt", {4'b0000, gnt}, 8'h00);
    chk("drop_to", {7'b0000000, timeout}, 8'h00);
    step(4'b0100, 1'b0, "after_drop");
    chk("after_drop_gnt", {4'b0000, gnt}, 8'h04);

    // Asynchronous reset in the middle of a grant to requester 2
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt", {4'b0000, gnt}, 8'h00);
    chk("arst_valid", {7'b0000000, gnt_valid}, 8'h00);
    check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b0, "post_rst");
    chk("post_rst_gnt", {4'b0000, gnt}, 8'h01);

    // Randomized traffic in phases of decreasing request volatility
    r = 4'b1111;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 9) < (6 - 2 * ph)) r = 4'($urandom_range(0, 15));
        d = ($urandom_range(0, 4 + 8 * ph) == 0);
        step(r, d, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
